mult_rr_scheduler: RTL
======================

// Module: mult_rr_scheduler
// PURPOSE
//  Shares one shift-add multiply datapath between NUM_REQ requesters.
//  - Round-robin arbitration among requesters.
//  - Sequences the partial-product steps one bit per cycle.
//  - Returns the 2*WIDTH product with a per-requester done pulse.
//  - Sits between the board-level requesters (switch/key front-ends) and the multiplier core.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  WIDTH    4  operand width; product is 2*WIDTH
// PORTS
//  clk_i    in   1                single clock, rising edge
//  rst_i    in   1                asynchronous, active-low reset
//  req_i    in   NUM_REQ          request per requester; level, held until granted
//  a_i      in   NUM_REQ*WIDTH    operand A per requester; slot k = [k*WIDTH +: WIDTH]
//  b_i      in   NUM_REQ*WIDTH    operand B per requester, same packing
//  gnt_o    out  NUM_REQ          one-hot grant, 1-cycle pulse
//  done_o   out  NUM_REQ          one-hot completion, 1-cycle pulse
//  y_o      out  2*WIDTH          product of the last completed job; held until the next END
//  busy_o   out  1                high when state != ST_IDLE
//  state_o  out  4                zero-extended FSM state, for debug display
// BEHAVIOUR
//  Reset (rst_i=0, async): all outputs 0; state=ST_IDLE; rr pointer=NUM_REQ-1, so req 0 has first priority.
//  FSM states (encoding 0/1/2):
//   ST_IDLE: when |req_i, at the edge:
//    - winner = first asserted req scanning ptr+1, ptr+2, ... modulo NUM_REQ
//    - latch A, B of winner; acc=0; bit_cnt=0; ptr=winner; gnt_o[winner]=1; go to ST_COMPUTE
//   ST_COMPUTE: each cycle
//    - acc += b_reg[bit_cnt] ? (a_reg << bit_cnt) : 0; bit_cnt++
//    - go to ST_END after the bit_cnt=WIDTH-1 step
//   ST_END: y_o <= acc; done_o[winner]=1 for this cycle; next state ST_IDLE unconditionally.
//  gnt_o is registered: high only in the first ST_COMPUTE cycle.
//  Latency: done_o is asserted WIDTH+1 cycles after the cycle in which req is sampled in ST_IDLE.
//   Back-to-back jobs cost WIDTH+2 cycles each (one ST_IDLE cycle between jobs).
//  Arithmetic: unsigned; acc is 2*WIDTH bits and cannot overflow; max product (2^WIDTH-1)^2.
//  req_i, a_i and b_i are ignored outside ST_IDLE. Operand changes after grant do not affect the running job.
//  A requester still holding req after its grant is re-arbitrated. The rotated pointer gives others priority first.
//  Simultaneous requests: exactly one grant per job, strictly round-robin; no starvation.
//  Reset mid-job aborts the job: no done_o, y_o=0. The requester must re-request.
// CONFIGURATION
//  MULT_EARLY_EXIT_EN defined:
//   - In ST_COMPUTE, if (b_reg >> (bit_cnt+1)) == 0 after the current step, go to ST_END now.
//   - Latency becomes (index of highest set bit of B)+2 cycles; B=0 gives 2 cycles.
//   - Results are identical.
//  Undefined: fixed WIDTH compute cycles, as above.
// STRUCTURE
//  Package mult_sched_pkg:
//   - state_t enum: ST_IDLE, ST_COMPUTE, ST_END
//   - STATE_W=4 display width
//   - function rr_pick(req, ptr) returning a one-hot pick
//  Sub-module mult_shift_add_dp holds:
//   - a_reg, b_reg, acc, bit_cnt
//   - inputs load, step; output last_step; output last_nz for early exit
//  mult_rr_scheduler holds the FSM, rr pointer, winner index, gnt/done/y registers.
// TESTING
//  1. Reset, then req=4'b0001, A0=4'hF, B0=4'hF:
//     gnt_o=0001 one cycle after sample; done_o=0001 at +5 cycles; y_o=8'hE1; busy_o low after.
//  2. req=4'b1111 held for 4 jobs, A=k+1, B=3 per slot k:
//     grant order 0,1,2,3; y_o = 03,06,09,0C; 6 cycles per job.
//  3. Job from req1 in flight; req0 and req2 rise mid-job:
//     no grant until ST_IDLE; next grant goes to 2 (ptr=1), then 0.
//  4. A3=4'h9, B3=4'h7; operands changed to 0 after gnt: y_o=8'h3F; req3 dropped after gnt.
//  5. rst_i pulsed low during ST_COMPUTE of job A=5, B=6:
//     immediate outputs 0, state_o=0, no done_o; a new request then gets 8'h1E.
//  6. MULT_EARLY_EXIT_EN, A=7:
//     B=0 gives done at +2 cycles, y=00; B=1 gives +2, y=07; B=8 gives +5, y=38.
//     Without the macro, all three take +5.

Source files
------------

// File: rtl/mult_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin multiply scheduler.
// Optional build macro used by the top: MULT_EARLY_EXIT_EN.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_END     = 2'd2
  } state_t;

  // Width of the debug state output, wider than the enum on purpose
  localparam int STATE_W = 4;

  // Upper bound on requesters; helpers work on vectors of this size
  localparam int MAX_REQ = 8;

  // Round-robin pick: first asserted request after ptr, wrapping at n.
  // Returns a one-hot vector (all zero when nothing is requested).
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input logic [3:0]         n);
    logic [MAX_REQ-1:0] pick;
    logic               found;
    logic [3:0]         idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= n) idx = idx - n;
      if ((4'(i) <= n) && !found && req[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

  // Index of the set bit in a one-hot vector (0 for an all-zero vector)
  function automatic logic [2:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mult_rr_scheduler_if.sv
// Requester-side bus of the multiply scheduler: requests and operands in,
// grant/done pulses, product and debug status out.
interface mult_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
);
  import mult_sched_pkg::*;

  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*WIDTH-1:0] a_i;
  logic [NUM_REQ*WIDTH-1:0] b_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic [NUM_REQ-1:0]       done_o;
  logic [2*WIDTH-1:0]       y_o;
  logic                     busy_o;
  logic [STATE_W-1:0]       state_o;

  // Requester front-end side
  modport master (
    output req_i, a_i, b_i,
    input  gnt_o, done_o, y_o, busy_o, state_o
  );

  // Scheduler side
  modport slave (
    input  req_i, a_i, b_i,
    output gnt_o, done_o, y_o, busy_o, state_o
  );

endinterface

// File: rtl/mult_rr_scheduler_dp.sv
// Shift-add multiply datapath: one partial product per step, LSB of B first.
module mult_shift_add_dp #(
  parameter int WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_step_o,
  output logic               last_nz_o,
  output logic [2*WIDTH-1:0] acc_next_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   aReg_q;
  logic [WIDTH-1:0]   bReg_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CNT_W-1:0]   bitCnt_q;
  logic [2*WIDTH-1:0] aExt;

  // Accumulator after the current step, plus the two finish conditions
  always_comb begin
    aExt        = {{WIDTH{1'b0}}, aReg_q};
    acc_d       = acc_q;
    if (bReg_q[bitCnt_q]) acc_d = acc_q + (aExt << bitCnt_q);
    last_step_o = (bitCnt_q == CNT_W'(WIDTH - 1));
    last_nz_o   = ((bReg_q >> (32'(bitCnt_q) + 32'd1)) == '0);
    acc_next_o  = acc_d;
  end

  // Operand capture on load, accumulate and advance on each step
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      aReg_q   <= '0;
      bReg_q   <= '0;
      acc_q    <= '0;
      bitCnt_q <= '0;
    end else if (load_i) begin
      aReg_q   <= a_i;
      bReg_q   <= b_i;
      acc_q    <= '0;
      bitCnt_q <= '0;
    end else if (step_i) begin
      acc_q    <= acc_d;
      bitCnt_q <= bitCnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one shift-add multiplier among NUM_REQ
// requesters. Build macro MULT_EARLY_EXIT_EN ends a job as soon as the
// remaining bits of B are zero; without it every job takes WIDTH steps.
module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mult_rr_scheduler_if.slave bus
);

`ifdef MULT_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t             state_q;
  state_t             state_d;
  logic [2:0]         ptr_q;
  logic [2:0]         winner_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [2*WIDTH-1:0] y_q;

  logic [MAX_REQ-1:0] reqPad;
  logic [2:0]         pickIdx;
  logic               anyReq;
  logic [WIDTH-1:0]   aSel;
  logic [WIDTH-1:0]   bSel;
  logic               load;
  logic               step;
  logic               finish;
  logic               lastStep;
  logic               lastNz;
  logic [2*WIDTH-1:0] accNext;

  // Arbitration: pick the next requester after the pointer and mux its operands
  always_comb begin
    reqPad              = '0;
    reqPad[NUM_REQ-1:0] = bus.req_i;
    anyReq              = |bus.req_i;
    pickIdx             = onehot_idx(rr_pick(reqPad, ptr_q, 4'(NUM_REQ)));
    aSel                = bus.a_i[int'(pickIdx)*WIDTH +: WIDTH];
    bSel                = bus.b_i[int'(pickIdx)*WIDTH +: WIDTH];
  end

  mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load),
    .step_i      (step),
    .a_i         (aSel),
    .b_i         (bSel),
    .last_step_o (lastStep),
    .last_nz_o   (lastNz),
    .acc_next_o  (accNext)
  );

  // Next-state logic and datapath controls
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = lastStep | (EARLY_EXIT & lastNz);
    case (state_q)
      ST_IDLE: begin
        if (anyReq) begin
          load    = 1'b1;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        step = 1'b1;
        if (finish) state_d = ST_END;
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Grant/pointer capture at job start; product and done pulse land together in ST_END
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q    <= 3'(NUM_REQ - 1);
      winner_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      y_q      <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      if (state_q == ST_IDLE && anyReq) begin
        gnt_q    <= NUM_REQ'(1) << pickIdx;
        ptr_q    <= pickIdx;
        winner_q <= pickIdx;
      end
      if (state_q == ST_COMPUTE && finish) begin
        done_q <= NUM_REQ'(1) << winner_q;
        y_q    <= accNext;
      end
    end
  end

  assign bus.gnt_o   = gnt_q;
  assign bus.done_o  = done_q;
  assign bus.y_o     = y_q;
  assign bus.busy_o  = (state_q != ST_IDLE);
  assign bus.state_o = STATE_W'(state_q);

endmodule
